// File: rtl/router_reg_if.sv
// Byte/strobe bundle between the router FSM, the input port and router_reg.
// master: the side that drives the byte stream and FSM strobes.
// slave:  router_reg itself.
interface router_reg_if #(
  parameter int unsigned DW = 8
);
  logic          packet_valid;
  logic [DW-1:0] datain;
  logic          fifo_full;
  logic          detect_add;
  logic          lfd_state;
  logic          ld_state;
  logic          laf_state;
  logic          full_state;
  logic          rst_int_reg;
  logic          parity_done;
  logic          low_packet_valid;
  logic          err;
  logic [DW-1:0] dout;

  modport master (
    output packet_valid, datain, fifo_full, detect_add, lfd_state,
           ld_state, laf_state, full_state, rst_int_reg,
    input  parity_done, low_packet_valid, err, dout
  );

  modport slave (
    input  packet_valid, datain, fifo_full, detect_add, lfd_state,
           ld_state, laf_state, full_state, rst_int_reg,
    output parity_done, low_packet_valid, err, dout
  );
endinterface

// File: rtl/router_reg.sv
// Datapath register block of the 1x3 packet router.
// Latches the header, steers header/payload onto dout, parks a byte that
// arrives while the destination FIFO is full and replays it afterwards.
// Optional parity checking is built when ROUTER_REG_PARITY_CHECK_EN is
// defined; otherwise err is tied low and the parity registers are absent.
module router_reg #(
  parameter int unsigned DW = 8
) (
  input  logic        clk,
  input  logic        resetn,
  router_reg_if.slave bus
);

  localparam int unsigned AW = 2;
  localparam logic [AW-1:0] ADDR_INVALID = 2'b11;

  logic [DW-1:0] hdr;
  logic [DW-1:0] full_byte;
  logic [DW-1:0] dout_q;
  logic          parity_done_q;
  logic          low_pv_q;
  logic          err_q;

  assign bus.dout             = dout_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = low_pv_q;
  assign bus.err              = err_q;

  // Header capture; destination address 3 does not exist and is ignored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hdr <= '0;
    end else if (bus.detect_add && bus.packet_valid &&
                 (bus.datain[AW-1:0] != ADDR_INVALID)) begin
      hdr <= bus.datain;
    end
  end

  // Output byte steering and parking of the byte seen while FIFO is full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q    <= '0;
      full_byte <= '0;
    end else if (bus.lfd_state) begin
      dout_q <= hdr;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_q <= bus.datain;
    end else if (bus.ld_state && bus.fifo_full) begin
      full_byte <= bus.datain;
    end else if (bus.laf_state) begin
      dout_q <= full_byte;
    end
  end

  // Remembers that packet_valid dropped while loading, until the FSM clears it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      low_pv_q <= 1'b0;
    end else if (bus.rst_int_reg) begin
      low_pv_q <= 1'b0;
    end else if (bus.ld_state && !bus.packet_valid) begin
      low_pv_q <= 1'b1;
    end
  end

  // Parity byte accepted, either directly or when replayed after a full FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_done_q <= 1'b0;
    end else if (bus.detect_add) begin
      parity_done_q <= 1'b0;
    end else if (bus.ld_state && !bus.fifo_full && !bus.packet_valid) begin
      parity_done_q <= 1'b1;
    end else if (bus.laf_state && low_pv_q && !parity_done_q) begin
      parity_done_q <= 1'b1;
    end
  end

`ifdef ROUTER_REG_PARITY_CHECK_EN
  logic [DW-1:0] int_parity;
  logic [DW-1:0] pkt_parity;

  // Running XOR over header and payload bytes of the current packet
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_parity <= '0;
    end else if (bus.detect_add) begin
      int_parity <= '0;
    end else if (bus.lfd_state) begin
      int_parity <= int_parity ^ hdr;
    end else if (bus.ld_state && bus.packet_valid && !bus.full_state) begin
      int_parity <= int_parity ^ bus.datain;
    end
  end

  // Trailing parity byte as sent by the source
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_parity <= '0;
    end else if (bus.ld_state && !bus.packet_valid && !bus.fifo_full) begin
      pkt_parity <= bus.datain;
    end
  end

  // Mismatch flag, evaluated while the parity byte is known to be in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (bus.detect_add) begin
      err_q <= 1'b0;
    end else if (parity_done_q) begin
      err_q <= (int_parity != pkt_parity);
    end
  end
`else
  // full_state only qualifies parity accumulation
  wire unused_full_state = bus.full_state;
  assign err_q = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: directed vector table, hand-written
// corner sequences, then random strobes against a packet-level model.
module tb_router_reg;

  localparam int unsigned DW = 8;
`ifdef ROUTER_REG_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic          pv;
    logic [DW-1:0] din;
    logic          ff;
    logic          det;
    logic          lfd;
    logic          ld;
    logic          laf;
    logic          full;
    logic          rii;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [10:0] exp;   // {dout, parity_done, low_packet_valid, err}
  } vec_t;

  logic clk;
  logic resetn;
  router_reg_if #(.DW(DW)) bus ();

  router_reg #(.DW(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  // Reference model: packet-level view, parity kept as a list of bytes
  logic [DW-1:0] m_hdr, m_hold, m_dout, m_pkt;
  logic          m_pd, m_lpv, m_err;
  logic [DW-1:0] m_q[$];

  function automatic logic [DW-1:0] xor_all();
    logic [DW-1:0] r;
    r = '0;
    foreach (m_q[i]) r = r ^ m_q[i];
    return r;
  endfunction

  task automatic model_reset();
    m_hdr = '0; m_hold = '0; m_dout = '0; m_pkt = '0;
    m_pd = 1'b0; m_lpv = 1'b0; m_err = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input stim_t s);
    logic [DW-1:0] o_hdr, o_hold;
    logic          o_pd, o_lpv, mism;
    o_hdr = m_hdr; o_hold = m_hold; o_pd = m_pd; o_lpv = m_lpv;
    mism = (xor_all() != m_pkt);
    if (s.det && s.pv && s.din[1:0] != 2'b11) m_hdr = s.din;
    if (s.lfd) m_dout = o_hdr;
    else if (s.ld) begin
      if (s.ff) m_hold = s.din;
      else      m_dout = s.din;
    end else if (s.laf) m_dout = o_hold;
    if (s.rii) m_lpv = 1'b0;
    else if (s.ld && !s.pv) m_lpv = 1'b1;
    if (s.det) m_pd = 1'b0;
    else if ((s.ld && !s.ff && !s.pv) || (s.laf && o_lpv && !o_pd)) m_pd = 1'b1;
    if (s.det) m_q.delete();
    else if (s.lfd) m_q.push_back(o_hdr);
    else if (s.ld && s.pv && !s.full) m_q.push_back(s.din);
    if (s.ld && !s.pv && !s.ff) m_pkt = s.din;
    if (!PAR_EN || s.det) m_err = 1'b0;
    else if (o_pd) m_err = mism;
  endtask

  function automatic logic [10:0] observed();
    return {bus.dout, bus.parity_done, bus.low_packet_valid, bus.err};
  endfunction

  function automatic logic [10:0] modeled();
    return {m_dout, m_pd, m_lpv, m_err};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got dout=%h pd=%b lpv=%b err=%b, want dout=%h pd=%b lpv=%b err=%b",
               name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic stim_t mk(input string kind, input logic pv, input logic [DW-1:0] din,
                               input logic ff);
    stim_t s;
    s = '0;
    s.pv = pv; s.din = din; s.ff = ff;
    case (kind)
      "det":  s.det  = 1'b1;
      "lfd":  s.lfd  = 1'b1;
      "ld":   s.ld   = 1'b1;
      "laf":  s.laf  = 1'b1;
      "full": s.full = 1'b1;
      "rii":  s.rii  = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  task automatic add(input string kind, input logic pv, input logic [DW-1:0] din, input logic ff,
                     input logic [DW-1:0] ed, input logic epd, input logic elpv, input logic eerr);
    vec_t v;
    v.s = mk(kind, pv, din, ff);
    v.exp = {ed, epd, elpv, eerr & PAR_EN};
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model
  task automatic apply(input stim_t s);
    bus.packet_valid = s.pv;
    bus.datain       = s.din;
    bus.fifo_full    = s.ff;
    bus.detect_add   = s.det;
    bus.lfd_state    = s.lfd;
    bus.ld_state     = s.ld;
    bus.laf_state    = s.laf;
    bus.full_state   = s.full;
    bus.rst_int_reg  = s.rii;
    @(posedge clk);
    #1;
    model_step(s);
  endtask

  initial begin
    stim_t s;
    int k;

    // Reset
    resetn = 1'b0;
    apply('0);
    model_reset();
    check("reset", observed(), 11'd0);
    resetn = 1'b1;

    // Good packet: header 22 (23 ignored), payload 01..80, parity DD
    add("det", 1, 8'h22, 0, 8'h00, 0, 0, 0);
    add("det", 1, 8'h23, 0, 8'h00, 0, 0, 0);
    add("lfd", 1, 8'h00, 0, 8'h22, 0, 0, 0);
    for (int i = 0; i < 8; i++) add("ld", 1, 8'(1 << i), 0, 8'(1 << i), 0, 0, 0);
    add("ld",   0, 8'hDD, 0, 8'hDD, 1, 1, 0);
    add("idle", 0, 8'h00, 0, 8'hDD, 1, 1, 0);
    add("rii",  0, 8'h00, 0, 8'hDD, 1, 0, 0);
    // Same packet, wrong parity byte
    add("det", 1, 8'h22, 0, 8'hDD, 0, 0, 0);
    add("lfd", 1, 8'h00, 0, 8'h22, 0, 0, 0);
    for (int i = 0; i < 8; i++) add("ld", 1, 8'(1 << i), 0, 8'(1 << i), 0, 0, 0);
    add("ld",   0, 8'h00, 0, 8'h00, 1, 1, 0);
    add("idle", 0, 8'h00, 0, 8'h00, 1, 1, 1);
    add("det",  1, 8'h41, 0, 8'h00, 0, 1, 0);
    add("rii",  0, 8'h00, 0, 8'h00, 0, 0, 0);
    // FIFO full while loading A5, replayed through LOAD_AFTER_FULL
    add("lfd",  1, 8'h00, 0, 8'h41, 0, 0, 0);
    add("ld",   1, 8'hA5, 1, 8'h41, 0, 0, 0);
    add("full", 1, 8'h00, 1, 8'h41, 0, 0, 0);
    add("laf",  1, 8'h00, 0, 8'hA5, 0, 0, 0);
    add("ld",   0, 8'hE4, 0, 8'hE4, 1, 1, 0);
    add("idle", 0, 8'h00, 0, 8'hE4, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].s);
      check($sformatf("vec%0d", i), observed(), tbl[i].exp);
    end

    // Parity byte arrives with FIFO full; it is replayed and closes the packet
    apply(mk("det", 1, 8'h12, 0));
    apply(mk("lfd", 1, 8'h00, 0));
    apply(mk("ld",  1, 8'hA1, 0));
    apply(mk("ld",  0, 8'hB3, 1));
    check("full_parity_hold", observed(), modeled());
    apply(mk("full", 0, 8'h00, 1));
    apply(mk("laf",  0, 8'h00, 0));
    check("laf_replay_dout", {bus.dout, bus.parity_done}, {8'hB3, 1'b1});
    apply(mk("idle", 0, 8'h00, 0));
    check("laf_replay_err", observed(), modeled());

    // Asynchronous reset in the middle of a packet
    apply(mk("det", 1, 8'h21, 0));
    apply(mk("lfd", 1, 8'h00, 0));
    apply(mk("ld",  0, 8'h5A, 0));
    #2 resetn = 1'b0;
    #1 check("async_reset", observed(), 11'd0);
    model_reset();
    apply('0);
    resetn = 1'b1;
    check("after_reset", observed(), modeled());

    // Random strobes against the model
    for (int i = 0; i < 400; i++) begin
      s = '0;
      k = $urandom_range(0, 11);
      if (k < 2)       s.det  = 1'b1;
      else if (k == 2) s.lfd  = 1'b1;
      else if (k < 6)  s.ld   = 1'b1;
      else if (k == 6) s.laf  = 1'b1;
      else if (k == 7) s.full = 1'b1;
      else if (k > 8)  {s.det, s.lfd, s.ld, s.laf, s.full} = 5'($urandom);
      s.pv  = ($urandom_range(0, 3) != 0);
      s.ff  = ($urandom_range(0, 3) == 0);
      s.rii = ($urandom_range(0, 7) == 0);
      s.din = 8'($urandom);
      apply(s);
      check($sformatf("rand%0d", i), observed(), modeled());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
